// File: rtl/zynq_seu_heal_sched_if.sv
// Handshake bundle between the SEU heal scheduler and the shared DPR engine.
// The scheduler drives the request and region select; the engine answers ack/done/err.
`timescale 1ns/1ps
interface zynq_seu_heal_sched_if #(
  parameter int CH_W = 2
);
  logic            dpr_req;
  logic [CH_W-1:0] dpr_ch;
  logic            dpr_ack;
  logic            dpr_done;
  logic            dpr_err;

  modport master (
    output dpr_req,
    output dpr_ch,
    input  dpr_ack,
    input  dpr_done,
    input  dpr_err
  );

  modport slave (
    input  dpr_req,
    input  dpr_ch,
    output dpr_ack,
    output dpr_done,
    output dpr_err
  );
endinterface

// File: rtl/zynq_seu_heal_sched.sv
// Latches SEFI edges from N_CH regions and heals them one at a time, round-robin,
// through a shared DPR engine with bounded retry, timeout and per-region quarantine.
`timescale 1ns/1ps
module zynq_seu_heal_sched #(
  parameter int N_CH        = 4,
  parameter int VETO_CYC    = 8,
  parameter int TIMEOUT_CYC = 4096,
  parameter int MAX_RETRY   = 2,
  parameter int COOL_CYC    = 16,
  parameter int CNT_W       = 16
) (
  input  logic                    clk_500mhz,
  input  logic                    rst,
  input  logic [N_CH-1:0]         sefi_flag,
  input  logic [N_CH-1:0]         fail_clr,
  zynq_seu_heal_sched_if.master   dpr,
  output logic [N_CH-1:0]         veto_pulse,
  output logic [N_CH-1:0]         ch_failed,
  output logic                    busy,
  output logic [CNT_W-1:0]        heal_count
);

  localparam int CH_W   = $clog2(N_CH);
  localparam int T_MAX0 = (VETO_CYC > COOL_CYC) ? VETO_CYC : COOL_CYC;
  localparam int T_MAX  = (TIMEOUT_CYC > T_MAX0) ? TIMEOUT_CYC : T_MAX0;
  localparam int T_W    = $clog2(T_MAX + 1);

  localparam logic [T_W-1:0]  VETO_LAST = T_W'(VETO_CYC - 1);
  localparam logic [T_W-1:0]  TMO_LAST  = T_W'(TIMEOUT_CYC - 1);
  localparam logic [T_W-1:0]  COOL_LAST = T_W'(COOL_CYC - 1);
  localparam logic [2:0]      MAX_R     = 3'(MAX_RETRY);
  localparam logic [CH_W-1:0] LAST_CH   = CH_W'(N_CH - 1);
  localparam logic [N_CH-1:0] ONE_HOT0  = {{(N_CH-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    VETO = 3'd1,
    REQ  = 3'd2,
    WAIT = 3'd3,
    COOL = 3'd4
  } state_t;

  state_t           state_reg;
  logic [CH_W-1:0]  sel_reg;
  logic [CH_W-1:0]  rr_reg;
  logic [2:0]       retry_reg;
  logic [T_W-1:0]   timer_reg;
  logic             dpr_req_reg;
  logic [CH_W-1:0]  dpr_ch_reg;
  logic [N_CH-1:0]  veto_reg;
  logic             busy_reg;

  logic [N_CH-1:0]  sefi_s_reg;
  logic [N_CH-1:0]  sefi_q_reg;
  logic [N_CH-1:0]  pending_reg;
  logic [N_CH-1:0]  pending_next;
  logic [N_CH-1:0]  failed_reg;
  logic [N_CH-1:0]  failed_next;
  logic [N_CH-1:0]  rise;
  logic [CNT_W-1:0] count_reg;

  logic             done_seen;
  logic             heal_ok;
  logic             tmo_hit;
  logic             heal_fail;
  logic             quarantine;
  logic [N_CH-1:0]  sel_oh;
  logic [CH_W-1:0]  rr_after_sel;

  logic             arb_found;
  logic [CH_W-1:0]  arb_idx;
  logic [N_CH-1:0]  arb_oh;

  // Heal outcome decode; a done in the same cycle as the timeout beats the timeout.
  assign done_seen    = (state_reg == WAIT) && dpr.dpr_done;
  assign heal_ok      = done_seen && !dpr.dpr_err;
  assign tmo_hit      = ((state_reg == REQ) || (state_reg == WAIT)) && (timer_reg == TMO_LAST);
  assign heal_fail    = (done_seen && dpr.dpr_err) || (tmo_hit && !done_seen);
  assign quarantine   = heal_fail && (retry_reg >= MAX_R);
  assign sel_oh       = ONE_HOT0 << sel_reg;
  assign rr_after_sel = (sel_reg == LAST_CH) ? '0 : sel_reg + 1'b1;

  // Scan downward so the pending channel closest to rr is the one left selected.
  always_comb begin
    logic [CH_W-1:0] cand;
    arb_found = 1'b0;
    arb_idx   = '0;
    cand      = '0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      cand = CH_W'((int'(rr_reg) + k) % N_CH);
      if (pending_reg[cand]) begin
        arb_found = 1'b1;
        arb_idx   = cand;
      end
    end
  end
  assign arb_oh = ONE_HOT0 << arb_idx;

  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_ch
      assign rise[gi]         = sefi_s_reg[gi] & ~sefi_q_reg[gi] & ~failed_reg[gi];
      assign pending_next[gi] = (rise[gi] | (pending_reg[gi] & ~(heal_ok & sel_oh[gi])))
                                & ~(quarantine & sel_oh[gi]);
      assign failed_next[gi]  = (failed_reg[gi] | (quarantine & sel_oh[gi])) & ~fail_clr[gi];
    end
  endgenerate

  always_ff @(posedge clk_500mhz) begin
    if (rst) begin
      sefi_s_reg  <= '0;
      sefi_q_reg  <= '0;
      pending_reg <= '0;
      failed_reg  <= '0;
      count_reg   <= '0;
    end else begin
      sefi_s_reg  <= sefi_flag;
      sefi_q_reg  <= sefi_s_reg;
      pending_reg <= pending_next;
      failed_reg  <= failed_next;
      if (heal_ok && (count_reg != {CNT_W{1'b1}})) begin
        count_reg <= count_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_500mhz) begin
    if (rst) begin
      state_reg   <= IDLE;
      sel_reg     <= '0;
      rr_reg      <= '0;
      retry_reg   <= '0;
      timer_reg   <= '0;
      dpr_req_reg <= 1'b0;
      dpr_ch_reg  <= '0;
      veto_reg    <= '0;
      busy_reg    <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (arb_found) begin
            sel_reg    <= arb_idx;
            dpr_ch_reg <= arb_idx;
            veto_reg   <= arb_oh;
            timer_reg  <= '0;
            busy_reg   <= 1'b1;
            state_reg  <= VETO;
          end
        end
        VETO: begin
          if (timer_reg == VETO_LAST) begin
            veto_reg    <= '0;
            dpr_req_reg <= 1'b1;
            timer_reg   <= '0;
            state_reg   <= REQ;
          end else begin
            timer_reg <= timer_reg + 1'b1;
          end
        end
        REQ, WAIT: begin
          if (heal_ok) begin
            retry_reg  <= '0;
            rr_reg     <= rr_after_sel;
            dpr_ch_reg <= '0;
            timer_reg  <= '0;
            state_reg  <= COOL;
          end else if (heal_fail) begin
            dpr_req_reg <= 1'b0;
            timer_reg   <= '0;
            if (!quarantine) begin
              retry_reg <= retry_reg + 3'd1;
              veto_reg  <= sel_oh;
              state_reg <= VETO;
            end else begin
              retry_reg  <= '0;
              rr_reg     <= rr_after_sel;
              dpr_ch_reg <= '0;
              state_reg  <= COOL;
            end
          end else begin
            // Timer spans REQ and WAIT together, so it keeps counting across the ack.
            timer_reg <= timer_reg + 1'b1;
            if ((state_reg == REQ) && dpr.dpr_ack) begin
              dpr_req_reg <= 1'b0;
              state_reg   <= WAIT;
            end
          end
        end
        COOL: begin
          if (timer_reg == COOL_LAST) begin
            timer_reg <= '0;
            busy_reg  <= 1'b0;
            state_reg <= IDLE;
          end else begin
            timer_reg <= timer_reg + 1'b1;
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign dpr.dpr_req = dpr_req_reg;
  assign dpr.dpr_ch  = dpr_ch_reg;
  assign veto_pulse  = veto_reg;
  assign ch_failed   = failed_reg;
  assign busy        = busy_reg;
  assign heal_count  = count_reg;

endmodule

// File: tb/tb_zynq_seu_heal_sched.sv
// Directed bench for the multi-channel SEU heal scheduler with a scripted DPR responder.
`timescale 1ns/1ps
module tb_zynq_seu_heal_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  sefi_flag = '0;
  logic [3:0]  fail_clr = '0;
  logic [3:0]  veto_pulse;
  logic [3:0]  ch_failed;
  logic        busy;
  logic [15:0] heal_count;

  int n_chk = 0;
  int n_pass = 0;

  int ack_dly = 3;
  int done_dly = 20;
  bit done_err = 1'b0;
  bit resp_en = 1'b0;

  int         burst_start [16];
  logic [3:0] burst_val [16];
  int         burst_len [16];
  int         req_rise [16];
  logic [1:0] req_ch [16];
  int         n_bursts;
  int         n_reqs;
  int         busy_fall;
  bit         watch_to;

  zynq_seu_heal_sched_if #(.CH_W(2)) dpr_bus ();

  zynq_seu_heal_sched #(
    .N_CH(4), .VETO_CYC(8), .TIMEOUT_CYC(64), .MAX_RETRY(2), .COOL_CYC(16), .CNT_W(16)
  ) dut (
    .clk_500mhz (clk),
    .rst        (rst),
    .sefi_flag  (sefi_flag),
    .fail_clr   (fail_clr),
    .dpr        (dpr_bus),
    .veto_pulse (veto_pulse),
    .ch_failed  (ch_failed),
    .busy       (busy),
    .heal_count (heal_count)
  );

  always #1 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // DPR engine model: ack ack_dly clocks after seeing req, then done after done_dly (<0: never).
  initial begin
    dpr_bus.dpr_ack  = 1'b0;
    dpr_bus.dpr_done = 1'b0;
    dpr_bus.dpr_err  = 1'b0;
    forever begin
      @(negedge clk);
      if (resp_en && dpr_bus.dpr_req) begin
        repeat (ack_dly) @(negedge clk);
        dpr_bus.dpr_ack = 1'b1;
        @(negedge clk);
        dpr_bus.dpr_ack = 1'b0;
        if (done_dly >= 0) begin
          repeat (done_dly) @(negedge clk);
          dpr_bus.dpr_done = 1'b1;
          dpr_bus.dpr_err  = done_err;
          @(negedge clk);
          dpr_bus.dpr_done = 1'b0;
          dpr_bus.dpr_err  = 1'b0;
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; sefi_flag = '0; fail_clr = '0; resp_en = 1'b0;
    tick(3);
    rst = 1'b0;
  endtask

  // Records veto bursts and request rises until busy has stayed low for 8 clocks.
  task automatic watch(input int max_cyc);
    logic [3:0] pv;
    logic pr, pb;
    int low;
    n_bursts = 0; n_reqs = 0; busy_fall = -1; watch_to = 1'b0; low = 0;
    for (int i = 0; i < 16; i++) begin
      burst_start[i] = -1; burst_val[i] = '0; burst_len[i] = 0; req_rise[i] = -1; req_ch[i] = '0;
    end
    pv = veto_pulse; pr = dpr_bus.dpr_req; pb = busy;
    for (int c = 1; c <= max_cyc; c++) begin
      @(negedge clk);
      if (veto_pulse != 0 && pv == 0) begin
        if (n_bursts < 16) begin
          burst_start[n_bursts] = c;
          burst_val[n_bursts] = veto_pulse;
        end
        $display("heal attempt %0d: veto=%b at cycle %0d", n_bursts, veto_pulse, c);
        n_bursts++;
      end
      if (veto_pulse != 0 && n_bursts > 0 && n_bursts <= 16) burst_len[n_bursts-1]++;
      if (dpr_bus.dpr_req && !pr) begin
        if (n_reqs < 16) begin
          req_rise[n_reqs] = c;
          req_ch[n_reqs] = dpr_bus.dpr_ch;
        end
        n_reqs++;
      end
      if (!busy && pb) busy_fall = c;
      if (busy) low = 0; else low++;
      if (low >= 8) return;
      pv = veto_pulse; pr = dpr_bus.dpr_req; pb = busy;
    end
    watch_to = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n_chk++; if (veto_pulse !== 4'b0) $display("FAIL reset_veto: got %b want 0000", veto_pulse); else n_pass++;
    n_chk++; if (dpr_bus.dpr_req !== 1'b0) $display("FAIL reset_req: got %b want 0", dpr_bus.dpr_req); else n_pass++;
    n_chk++; if (dpr_bus.dpr_ch !== 2'd0) $display("FAIL reset_ch: got %0d want 0", dpr_bus.dpr_ch); else n_pass++;
    n_chk++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
    n_chk++; if (ch_failed !== 4'b0) $display("FAIL reset_failed: got %b want 0000", ch_failed); else n_pass++;
    n_chk++; if (heal_count !== 16'd0) $display("FAIL reset_count: got %0d want 0", heal_count); else n_pass++;
  endtask

  task automatic test_single();
    do_reset();
    ack_dly = 3; done_dly = 20; done_err = 1'b0; resp_en = 1'b1;
    @(negedge clk); sefi_flag = 4'b0100;
    watch(500);
    n_chk++; if (watch_to !== 1'b0) $display("FAIL single_watch: got timeout %b want 0", watch_to); else n_pass++;
    n_chk++; if (n_bursts !== 1) $display("FAIL single_bursts: got %0d want 1", n_bursts); else n_pass++;
    n_chk++; if (burst_val[0] !== 4'b0100) $display("FAIL single_veto: got %b want 0100", burst_val[0]); else n_pass++;
    n_chk++; if (burst_start[0] !== 3) $display("FAIL single_latency: got %0d want 3", burst_start[0]); else n_pass++;
    n_chk++; if (burst_len[0] !== 8) $display("FAIL single_veto_len: got %0d want 8", burst_len[0]); else n_pass++;
    n_chk++; if (req_rise[0] !== 11) $display("FAIL single_req_cycle: got %0d want 11", req_rise[0]); else n_pass++;
    n_chk++; if (req_ch[0] !== 2'd2) $display("FAIL single_dpr_ch: got %0d want 2", req_ch[0]); else n_pass++;
    n_chk++; if (busy_fall !== 52) $display("FAIL single_cool_end: got %0d want 52", busy_fall); else n_pass++;
    n_chk++; if (heal_count !== 16'd1) $display("FAIL single_count: got %0d want 1", heal_count); else n_pass++;
    n_chk++; if (ch_failed !== 4'b0) $display("FAIL single_failed: got %b want 0000", ch_failed); else n_pass++;
    // rr now points at 3, so ch3 is served ahead of ch0.
    sefi_flag = 4'b0000; tick(4);
    sefi_flag = 4'b1001;
    watch(1000);
    n_chk++; if (n_bursts !== 2) $display("FAIL rr_bursts: got %0d want 2", n_bursts); else n_pass++;
    n_chk++; if (burst_val[0] !== 4'b1000) $display("FAIL rr_first: got %b want 1000", burst_val[0]); else n_pass++;
    n_chk++; if (burst_val[1] !== 4'b0001) $display("FAIL rr_second: got %b want 0001", burst_val[1]); else n_pass++;
    n_chk++; if (heal_count !== 16'd3) $display("FAIL rr_count: got %0d want 3", heal_count); else n_pass++;
  endtask

  task automatic test_multi();
    do_reset();
    ack_dly = 3; done_dly = 20; done_err = 1'b0; resp_en = 1'b1;
    @(negedge clk); sefi_flag = 4'b1011;
    watch(2000);
    n_chk++; if (n_bursts !== 3) $display("FAIL multi_bursts: got %0d want 3", n_bursts); else n_pass++;
    n_chk++; if (req_ch[0] !== 2'd0) $display("FAIL multi_order0: got %0d want 0", req_ch[0]); else n_pass++;
    n_chk++; if (req_ch[1] !== 2'd1) $display("FAIL multi_order1: got %0d want 1", req_ch[1]); else n_pass++;
    n_chk++; if (req_ch[2] !== 2'd3) $display("FAIL multi_order2: got %0d want 3", req_ch[2]); else n_pass++;
    n_chk++; if (burst_val[2] !== 4'b1000) $display("FAIL multi_veto2: got %b want 1000", burst_val[2]); else n_pass++;
    n_chk++; if (heal_count !== 16'd3) $display("FAIL multi_count: got %0d want 3", heal_count); else n_pass++;
    sefi_flag = 4'b0000; tick(4);
    sefi_flag = 4'b0110;
    watch(2000);
    n_chk++; if (burst_val[0] !== 4'b0010) $display("FAIL multi_wrap_first: got %b want 0010", burst_val[0]); else n_pass++;
    n_chk++; if (burst_val[1] !== 4'b0100) $display("FAIL multi_wrap_second: got %b want 0100", burst_val[1]); else n_pass++;
    n_chk++; if (heal_count !== 16'd5) $display("FAIL multi_count2: got %0d want 5", heal_count); else n_pass++;
  endtask

  task automatic test_retry_quarantine();
    do_reset();
    ack_dly = 3; done_dly = 5; done_err = 1'b1; resp_en = 1'b1;
    @(negedge clk); sefi_flag = 4'b0010;
    watch(2000);
    n_chk++; if (n_bursts !== 3) $display("FAIL retry_bursts: got %0d want 3", n_bursts); else n_pass++;
    for (int k = 0; k < 3; k++) begin
      n_chk++; if (burst_val[k] !== 4'b0010) $display("FAIL retry_veto%0d: got %b want 0010", k, burst_val[k]); else n_pass++;
    end
    n_chk++; if (burst_start[1] - burst_start[0] !== 18) $display("FAIL retry_spacing: got %0d want 18", burst_start[1] - burst_start[0]); else n_pass++;
    n_chk++; if (ch_failed !== 4'b0010) $display("FAIL retry_failed: got %b want 0010", ch_failed); else n_pass++;
    n_chk++; if (heal_count !== 16'd0) $display("FAIL retry_count: got %0d want 0", heal_count); else n_pass++;
    sefi_flag = 4'b0000; tick(4);
    sefi_flag = 4'b0010;
    watch(40);
    n_chk++; if (n_bursts !== 0) $display("FAIL quar_edge_dropped: got %0d bursts want 0", n_bursts); else n_pass++;
    n_chk++; if (busy_fall !== -1) $display("FAIL quar_busy: got fall at %0d want none", busy_fall); else n_pass++;
    @(negedge clk); fail_clr = 4'b0010;
    @(negedge clk); fail_clr = 4'b0000;
    n_chk++; if (ch_failed !== 4'b0000) $display("FAIL fail_clr: got %b want 0000", ch_failed); else n_pass++;
    watch(40);
    n_chk++; if (n_bursts !== 0) $display("FAIL fail_clr_no_pending: got %0d bursts want 0", n_bursts); else n_pass++;
    done_err = 1'b0;
    sefi_flag = 4'b0000; tick(4);
    sefi_flag = 4'b0010;
    watch(500);
    n_chk++; if (n_bursts !== 1) $display("FAIL reheal_bursts: got %0d want 1", n_bursts); else n_pass++;
    n_chk++; if (heal_count !== 16'd1) $display("FAIL reheal_count: got %0d want 1", heal_count); else n_pass++;
  endtask

  task automatic test_timeout();
    do_reset();
    ack_dly = 3; done_dly = -1; done_err = 1'b0; resp_en = 1'b1;
    @(negedge clk); sefi_flag = 4'b1000;
    watch(2000);
    n_chk++; if (n_bursts !== 3) $display("FAIL tmo_bursts: got %0d want 3", n_bursts); else n_pass++;
    n_chk++; if (burst_start[1] - req_rise[0] !== 64) $display("FAIL tmo_try0: got %0d want 64", burst_start[1] - req_rise[0]); else n_pass++;
    n_chk++; if (burst_start[2] - req_rise[1] !== 64) $display("FAIL tmo_try1: got %0d want 64", burst_start[2] - req_rise[1]); else n_pass++;
    n_chk++; if (ch_failed !== 4'b1000) $display("FAIL tmo_failed: got %b want 1000", ch_failed); else n_pass++;
    n_chk++; if (heal_count !== 16'd0) $display("FAIL tmo_count: got %0d want 0", heal_count); else n_pass++;
    // No ack at all: the timeout must also fire from REQ.
    resp_en = 1'b0;
    sefi_flag = 4'b0000; tick(4);
    sefi_flag = 4'b0001;
    watch(2000);
    n_chk++; if (n_bursts !== 3) $display("FAIL noack_bursts: got %0d want 3", n_bursts); else n_pass++;
    n_chk++; if (burst_start[1] - req_rise[0] !== 64) $display("FAIL noack_try0: got %0d want 64", burst_start[1] - req_rise[0]); else n_pass++;
    n_chk++; if (ch_failed !== 4'b1001) $display("FAIL noack_failed: got %b want 1001", ch_failed); else n_pass++;
  endtask

  task automatic test_coincide();
    do_reset();
    ack_dly = 3; done_dly = 59; done_err = 1'b0; resp_en = 1'b1;
    @(negedge clk); sefi_flag = 4'b0001;
    watch(1000);
    n_chk++; if (n_bursts !== 1) $display("FAIL coincide_bursts: got %0d want 1", n_bursts); else n_pass++;
    n_chk++; if (heal_count !== 16'd1) $display("FAIL coincide_count: got %0d want 1", heal_count); else n_pass++;
    n_chk++; if (ch_failed !== 4'b0000) $display("FAIL coincide_failed: got %b want 0000", ch_failed); else n_pass++;
  endtask

  task automatic test_reset_mid();
    bit found;
    do_reset();
    ack_dly = 3; done_dly = 20; done_err = 1'b0; resp_en = 1'b1;
    @(negedge clk); sefi_flag = 4'b0100;
    watch(500);
    n_chk++; if (heal_count !== 16'd1) $display("FAIL mid_pre_count: got %0d want 1", heal_count); else n_pass++;
    sefi_flag = 4'b0000; tick(4);
    sefi_flag = 4'b0100;
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(negedge clk);
      if (dpr_bus.dpr_req) found = 1'b1;
    end
    n_chk++; if (found !== 1'b1) $display("FAIL mid_req_seen: got %b want 1", found); else n_pass++;
    tick(6);
    n_chk++; if ({dpr_bus.dpr_req, busy} !== 2'b01) $display("FAIL mid_in_wait: got req,busy=%b want 01", {dpr_bus.dpr_req, busy}); else n_pass++;
    rst = 1'b1; sefi_flag = 4'b0000; resp_en = 1'b0;
    tick(1);
    n_chk++; if (dpr_bus.dpr_req !== 1'b0) $display("FAIL mid_rst_req: got %b want 0", dpr_bus.dpr_req); else n_pass++;
    n_chk++; if (veto_pulse !== 4'b0) $display("FAIL mid_rst_veto: got %b want 0000", veto_pulse); else n_pass++;
    n_chk++; if (busy !== 1'b0) $display("FAIL mid_rst_busy: got %b want 0", busy); else n_pass++;
    n_chk++; if (heal_count !== 16'd0) $display("FAIL mid_rst_count: got %0d want 0", heal_count); else n_pass++;
    rst = 1'b0;
    watch(100);
    n_chk++; if (n_bursts !== 0) $display("FAIL mid_rst_pending: got %0d bursts want 0", n_bursts); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_multi();
    test_retry_quarantine();
    test_timeout();
    test_coincide();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
